alu_op_sequencer: RTL and testbench

Multi-cycle issue/writeback controller that drives the 16-bit combinational `alu` from decoded R-type operations. It holds an 8-entry × 16-bit register file, reads the operands, presents `ReadData1`/`ReadData2`/`Control` to the ALU, captures `WriteData`/`Overflow`, and writes the result back. It sits between instruction decode and the `alu`, on the driving side of the ALU's operand/control interface.

---
 rtl/alu_op_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Multi-cycle issue/writeback controller for the 16-bit combinational alu.
// Holds an 8 x 16 register file and sequences IDLE -> READ -> EXEC -> WB per operation.
module alu_op_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  funct,
  input  logic [2:0]  rs,
  input  logic [2:0]  rt,
  input  logic [2:0]  rd,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic [15:0] ReadData1,
  output logic [15:0] ReadData2,
  output logic [3:0]  Control,
  input  logic [15:0] WriteData,
  input  logic        Overflow,
  output logic        done,
  output logic [15:0] result,
  output logic        ovf,
  output logic        illegal,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_NOR = 6'b100111;

  state_t      state, state_nxt;
  logic [5:0]  op_funct;
  logic [2:0]  op_rs, op_rt, op_rd;
  logic [15:0] regs [0:7];

  logic [3:0]  dec_ctrl;
  logic        dec_illegal;
  logic        dec_addsub;
  logic        accept;
  logic        wb_en;
  logic        ld_fire;

  // ---------------------------------------------------------------- control
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_READ;
      end
      S_READ: state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_WB;
      S_WB: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = (state == S_IDLE) && in_valid;

  // Operation fields are captured once at accept; later in_valid traffic is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_funct <= '0;
      op_rs    <= '0;
      op_rt    <= '0;
      op_rd    <= '0;
    end else if (accept) begin
      op_funct <= funct;
      op_rs    <= rs;
      op_rt    <= rt;
      op_rd    <= rd;
    end
  end

  // ----------------------------------------------------------------- decode
  always_comb begin
    dec_ctrl    = 4'b0000;
    dec_illegal = 1'b0;
    dec_addsub  = 1'b0;
    unique case (op_funct)
      F_AND: dec_ctrl = 4'b0000;
      F_OR:  dec_ctrl = 4'b0001;
      F_ADD: begin dec_ctrl = 4'b0010; dec_addsub = 1'b1; end
      F_SUB: begin dec_ctrl = 4'b0110; dec_addsub = 1'b1; end
      F_SLT: dec_ctrl = 4'b0111;
      F_NOR: dec_ctrl = 4'b1100;
      default: dec_illegal = 1'b1;
    endcase
  end

  // --------------------------------------------------------------- datapath
  // Operands/control change only in READ, giving the ALU all of EXEC to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReadData1 <= '0;
      ReadData2 <= '0;
      Control   <= '0;
    end else if (state == S_READ) begin
      ReadData1 <= regs[op_rs];
      ReadData2 <= regs[op_rt];
      Control   <= dec_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      ovf     <= 1'b0;
      illegal <= 1'b0;
    end else if (state == S_EXEC) begin
      result  <= dec_illegal ? 16'h0000 : WriteData;
      ovf     <= dec_addsub & Overflow;
      illegal <= dec_illegal;
    end
  end

  // ---------------------------------------------------------- register file
  // Register 0 is never written, so it reads as zero without a read-side mux.
  assign ld_fire = (state == S_IDLE) && ld_en && (ld_addr != 3'd0);
  assign wb_en   = (state == S_WB) && (op_rd != 3'd0) && !illegal && !ovf;

  // NOTE: the register file is reset explicitly because reset must clear architectural state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (ld_fire) begin
      regs[ld_addr] <= ld_data;
    end else if (wb_en) begin
      regs[op_rd] <= result;
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 16-bit alu closing the loop.
// Expected values are hand-computed constants; the alu model only supplies WriteData/Overflow.
module tb_alu_op_sequencer;

  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_NOR = 6'b100111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [5:0]  funct;
  logic [2:0]  rs, rt, rd;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] ReadData1, ReadData2;
  logic [3:0]  Control;
  logic [15:0] WriteData;
  logic        Overflow;
  logic        done;
  logic [15:0] result;
  logic        ovf, illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Control(Control),
    .WriteData(WriteData), .Overflow(Overflow),
    .done(done), .result(result), .ovf(ovf), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural alu on the far side of the operand/control interface.
  always_comb begin
    WriteData = 16'h0000;
    Overflow  = 1'b0;
    case (Control)
      4'b0000: WriteData = ReadData1 & ReadData2;
      4'b0001: WriteData = ReadData1 | ReadData2;
      4'b0010: begin
        WriteData = ReadData1 + ReadData2;
        Overflow  = (ReadData1[15] == ReadData2[15]) && (WriteData[15] != ReadData1[15]);
      end
      4'b0110: begin
        WriteData = ReadData1 - ReadData2;
        Overflow  = (ReadData1[15] != ReadData2[15]) && (WriteData[15] != ReadData1[15]);
      end
      4'b0111: WriteData = ($signed(ReadData1) < $signed(ReadData2)) ? 16'h0001 : 16'h0000;
      4'b1100: WriteData = ~(ReadData1 | ReadData2);
      default: WriteData = 16'h0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Accept one op, wait (bounded) for done, then compare the completion outputs.
  task automatic issue(input string tag, input logic [5:0] f, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] d, input logic [15:0] exp_res,
                       input logic [3:0] exp_ctl, input logic exp_ovf, input logic exp_ill);
    int n;
    check({tag, ".ready"}, in_ready, 1);
    funct = f; rs = a; rt = b; rd = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!done && n < 10) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, n, 3);
    check({tag, ".result"}, result, exp_res);
    check({tag, ".control"}, Control, exp_ctl);
    check({tag, ".ovf"}, ovf, exp_ovf);
    check({tag, ".illegal"}, illegal, exp_ill);
    tick();
    check({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int low_cnt;
    rst_n = 1'b0; in_valid = 1'b0; funct = '0; rs = '0; rt = '0; rd = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    #23;
    check("rst.done", done, 0);
    check("rst.result", result, 16'h0000);
    check("rst.control", Control, 4'b0000);
    check("rst.rd1", ReadData1, 16'h0000);
    rst_n = 1'b1;
    #1;
    check("rst.ready", in_ready, 1);
    @(negedge clk);
    #1;

    // Logic/arith sweep on r1=0x0F0F, r2=0xF0F0.
    preload(3'd1, 16'h0F0F);
    preload(3'd2, 16'hF0F0);
    issue("and", F_AND, 3'd1, 3'd2, 3'd3, 16'h0000, 4'b0000, 0, 0);
    issue("or",  F_OR,  3'd1, 3'd2, 3'd4, 16'hFFFF, 4'b0001, 0, 0);
    issue("add", F_ADD, 3'd1, 3'd2, 3'd5, 16'hFFFF, 4'b0010, 0, 0);
    issue("sub", F_SUB, 3'd1, 3'd2, 3'd6, 16'h1E1F, 4'b0110, 0, 0);
    issue("slt", F_SLT, 3'd1, 3'd2, 3'd7, 16'h0000, 4'b0111, 0, 0);
    issue("nor", F_NOR, 3'd1, 3'd2, 3'd3, 16'h0000, 4'b1100, 0, 0);
    check_reg("wb.r4", 3'd4, 16'hFFFF);
    check_reg("wb.r6", 3'd6, 16'h1E1F);

    // Overflow trap leaves the destination untouched.
    preload(3'd3, 16'h7FFF);
    preload(3'd4, 16'h0001);
    preload(3'd5, 16'h1234);
    issue("add_ovf", F_ADD, 3'd3, 3'd4, 3'd5, 16'h8000, 4'b0010, 1, 0);
    check_reg("ovf.r5", 3'd5, 16'h1234);
    issue("sub_noovf", F_SUB, 3'd4, 3'd3, 3'd6, 16'h8002, 4'b0110, 0, 0);
    check_reg("sub.r6", 3'd6, 16'h8002);

    // Register 0 discards writes.
    issue("or_r0", F_OR, 3'd1, 3'd2, 3'd0, 16'hFFFF, 4'b0001, 0, 0);
    check_reg("r0.wb", 3'd0, 16'h0000);
    preload(3'd0, 16'h1234);
    check_reg("r0.ld", 3'd0, 16'h0000);

    // Unknown funct.
    preload(3'd7, 16'hABCD);
    issue("illegal", 6'b000000, 3'd1, 3'd2, 3'd7, 16'h0000, 4'b0000, 0, 1);
    check_reg("ill.r7", 3'd7, 16'hABCD);

    // Back-to-back in_valid: only IDLE-cycle fields execute; ld_en in EXEC ignored.
    for (int a = 3; a < 8; a++) preload(a[2:0], 16'h0000);
    low_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      if (c % 4 == 0) begin
        funct = F_ADD; rs = (c == 0) ? 3'd1 : 3'd2; rt = 3'd0; rd = (c == 0) ? 3'd3 : 3'd4;
      end else begin
        funct = F_OR; rs = 3'd1; rt = 3'd2; rd = 3'(5 + (c % 3));
      end
      check($sformatf("stream.ready%0d", c), in_ready, (c % 4 == 0) ? 1 : 0);
      if (!in_ready) low_cnt++;
      ld_en = (c == 2); ld_addr = 3'd5; ld_data = 16'hDEAD;
      tick();
      ld_en = 1'b0;
    end
    in_valid = 1'b0;
    check("stream.low_cnt", low_cnt, 6);
    check_reg("stream.r3", 3'd3, 16'h0F0F);
    check_reg("stream.r4", 3'd4, 16'hF0F0);
    check_reg("stream.r5", 3'd5, 16'h0000);
    check_reg("stream.r6", 3'd6, 16'h0000);
    check_reg("stream.r7", 3'd7, 16'h0000);

    // Reset during EXEC aborts the op and clears everything at once.
    preload(3'd6, 16'h5555);
    funct = F_ADD; rs = 3'd1; rt = 3'd2; rd = 3'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("abort.ctl_pre", Control, 4'b0010);
    rst_n = 1'b0;
    #1;
    check("abort.done", done, 0);
    check("abort.rd1", ReadData1, 16'h0000);
    check("abort.rd2", ReadData2, 16'h0000);
    check("abort.control", Control, 4'b0000);
    check("abort.result", result, 16'h0000);
    check("abort.ovf", ovf, 0);
    check("abort.illegal", illegal, 0);
    check_reg("abort.r6", 3'd6, 16'h0000);
    check_reg("abort.r1", 3'd1, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("abort.no_done%0d", k), done, 0);
    end
    rst_n = 1'b1;
    tick();
    check("abort.ready", in_ready, 1);
    check("abort.done_after", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
